log_stream: RTL and testbench
=============================

LOG_STREAM -- requirements
Module: log_stream

Interface
REQ-001 Parameter W, default 16, data width of input mantissa and output result.
REQ-002 Parameter LOG_PREC, default 10, fractional bits of internal mantissa log; LOG_PREC ≤ W.
REQ-003 Parameter OUT_QUANT, default 12, fractional bits of output; LOG_PREC ≤ OUT_QUANT ≤ W-2.
REQ-004 Parameter TAG_W, default 4, width of sideband tag carried with each sample.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  input sample present.
REQ-008 in_ready  output  1  block accepts sample this cycle.
REQ-009 a  input  W  unsigned mantissa.
REQ-010 a_quant  input  8  signed; input value x = a * 2^(-a_quant).
REQ-011 mode  input  1  0 = natural log, 1 = log2; sampled per transaction.
REQ-012 in_tag  input  TAG_W  sideband, returned unchanged with result.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 z  output  W  signed two's-complement log result, OUT_QUANT fractional bits.
REQ-016 out_tag  output  TAG_W  tag of the sample in z.
REQ-017 out_zero  output  1  input was a == 0.
REQ-018 out_sat  output  1  result saturated.
REQ-019 sat_clr  input  1  synchronous clear of sat_count.
REQ-020 sat_count  output  16  count of saturated results delivered.

Function
REQ-021 Transfer on in side when in_valid && in_ready; on out side when out_valid && out_ready.
REQ-022 Three-stage pipeline: S1 leading-one detect/normalise, S2 mantissa log2 (LOG_PREC frac bits), S3 exponent add, ln scaling, rounding, saturation.
REQ-023 Latency: result valid exactly 3 cycles after acceptance when no stall; throughput one sample per cycle.
REQ-024 Each stage advances when next stage empty or advancing; stalled stage holds data, tag, mode, flags unchanged.
REQ-025 in_ready = !S1_full || S1_advances; combinational from out_ready permitted; no data loss or duplication under any valid/ready pattern.
REQ-026 Capacity 3 samples; with out_ready held low, exactly 3 samples accepted before in_ready = 0.
REQ-027 log2(x) = (p - a_quant) + log2(1.f), p = index of MSB set in a, f = bits below MSB truncated to LOG_PREC.
REQ-028 mode=1: z = round-half-up(log2(x) * 2^OUT_QUANT); mode=0: z = round-half-up(log2(x) * ln2 * 2^OUT_QUANT), ln2 constant with ≥ OUT_QUANT+2 frac bits.
REQ-029 Accuracy: |z - exact| ≤ 2 LSB for non-saturated results.
REQ-030 a == 0: z = 1 followed by W-1 zeros (min code), out_zero = 1, out_sat = 0.
REQ-031 Result > 2^(W-1)-1: z = 2^(W-1)-1, out_sat = 1; result < -(2^(W-1)-1): z = -(2^(W-1)-1), out_sat = 1; min code reserved for zero.
REQ-032 Internal exponent/product widths sized so no intermediate wrap for any a, a_quant in full range.
REQ-033 sat_count increments on each out-side transfer with out_sat = 1; holds at 0xFFFF; sat_clr clears to 0 next cycle, clear wins over simultaneous increment.
REQ-034 out_valid, z, out_tag, out_zero, out_sat stable while out_valid && !out_ready.

Reset
REQ-035 rst_n low asynchronously empties all stages: out_valid = 0, z = 0, out_tag = 0, out_zero = 0, out_sat = 0, sat_count = 0.
REQ-036 in_ready = 1 from first cycle after rst_n deasserts; samples in flight at reset are discarded, never emitted.

Verification (W=16, LOG_PREC=10, OUT_QUANT=12)
REQ-037 a=1, a_quant=0, mode=1, out_ready=1 -> z=0x0000 three cycles later, flags 0.
REQ-038 a=2, a_quant=0: mode=1 -> z=0x1000; mode=0 -> z=0x0B17 ±2; tags 3 and 5 returned in order.
REQ-039 a=0, tag=7 -> z=0x8000, out_zero=1, out_tag=7.
REQ-040 a=0xFFFF, a_quant=-20, mode=1 -> z=0x7FFF, out_sat=1, sat_count 0->1; sat_clr -> 0.
REQ-041 out_ready low, in_valid high for 5 cycles -> 3 accepted, in_ready=0; out_ready high -> 3 results in order, then streaming resumes, no loss.
REQ-042 rst_n low with 2 samples in flight -> out_valid=0 immediately; after release no stale result emitted.

Source files
------------

// File: rtl/log_stream.sv
// Streaming fixed-point logarithm (ln or log2) of a * 2^-a_quant, with sideband tag and saturation counter.
// Latency: 3 cycles (normalise, mantissa log, scale/round/saturate); one sample per cycle.
// Backpressure: valid/ready per stage; in_ready follows out_ready combinationally when the pipe is full.
module log_stream #(
    parameter int W         = 16,
    parameter int LOG_PREC  = 10,
    parameter int OUT_QUANT = 12,
    parameter int TAG_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            a,
    input  logic signed [7:0]       a_quant,
    input  logic                    mode,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            z,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_zero,
    output logic                    out_sat,
    input  logic                    sat_clr,
    output logic [15:0]             sat_count
);

    localparam int PW  = (W > 1) ? $clog2(W) : 1;
    localparam int EW  = PW + 10;
    // Mantissa log keeps two guard bits below LOG_PREC so the final rounding stays within 2 LSB.
    localparam int LF  = LOG_PREC + 2;
    localparam int YF  = LOG_PREC + 8;
    localparam int YW  = YF + 2;
    localparam int LW  = EW + LF;
    localparam int CF  = OUT_QUANT + 4;
    localparam int PRW = LW + CF + 2;
    localparam int SH  = LF + CF - OUT_QUANT;

    localparam logic [63:0]            LN2_64 = 64'hB17217F7D1CF79AB;
    localparam logic [CF:0]            LN2_C  = (CF+1)'(((LN2_64 >> (63 - CF)) + 64'd1) >> 1);
    localparam logic [CF:0]            ONE_C  = {1'b1, {CF{1'b0}}};
    localparam logic signed [PRW-1:0]  HALF   = PRW'(64'd1 << (SH - 1));
    localparam logic signed [PRW-1:0]  MAX_P  = PRW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [PRW-1:0]  MIN_P  = -MAX_P;

    logic                v1, v2;
    logic [PW-1:0]       p1, p2;
    logic [LOG_PREC-1:0] f1;
    logic [LF-1:0]       m2;
    logic                zero1, zero2, mode1, mode2;
    logic signed [7:0]   aq1, aq2;
    logic [TAG_W-1:0]    tag1, tag2;

    logic adv1, adv2, in_fire;

    assign adv2     = v2 && (!out_valid || out_ready);
    assign adv1     = v1 && (!v2 || adv2);
    assign in_ready = !v1 || adv1;
    assign in_fire  = in_valid && in_ready;

    // S1: leading-one detect and normalise
    logic [PW-1:0]          p_lod;
    logic [W+LOG_PREC-1:0]  ext;
    logic [LOG_PREC-1:0]    f_nxt;

    always_comb begin
        p_lod = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) p_lod = PW'(i);
        end
        ext   = {a, {LOG_PREC{1'b0}}} << (PW'(W - 1) - p_lod);
        f_nxt = LOG_PREC'(ext >> (W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; p1 <= '0; f1 <= '0; zero1 <= 1'b0;
            aq1 <= '0; mode1 <= 1'b0; tag1 <= '0;
        end else begin
            v1 <= in_fire || (v1 && !adv1);
            if (in_fire) begin
                p1    <= p_lod;
                f1    <= f_nxt;
                zero1 <= (a == '0);
                aq1   <= a_quant;
                mode1 <= mode;
                tag1  <= in_tag;
            end
        end
    end

    // S2: log2(1.f) by repeated squaring; each square >= 2 yields a one bit
    logic [YW-1:0]   y;
    logic [2*YW-1:0] sq;
    logic [LF-1:0]   m_nxt;

    always_comb begin
        y     = {2'b01, f1, {(YF - LOG_PREC){1'b0}}};
        sq    = '0;
        m_nxt = '0;
        for (int i = 0; i < LF; i++) begin
            sq = {{YW{1'b0}}, y} * {{YW{1'b0}}, y};
            if (sq[2*YF+1]) begin
                m_nxt[LF-1-i] = 1'b1;
                y = YW'(sq >> (YF + 1));
            end else begin
                y = YW'(sq >> YF);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0; p2 <= '0; m2 <= '0; zero2 <= 1'b0;
            aq2 <= '0; mode2 <= 1'b0; tag2 <= '0;
        end else begin
            v2 <= adv1 || (v2 && !adv2);
            if (adv1) begin
                p2    <= p1;
                m2    <= m_nxt;
                zero2 <= zero1;
                aq2   <= aq1;
                mode2 <= mode1;
                tag2  <= tag1;
            end
        end
    end

    // S3: exponent add, optional ln2 scaling, round-half-up, saturate
    logic signed [EW-1:0]  p_s, aq_s, e;
    logic signed [LW-1:0]  lval;
    logic signed [PRW-1:0] l_ext, c_ext, prod, rnd, r;
    logic [W-1:0]          z_nxt;
    logic                  sat_nxt;

    always_comb begin
        p_s   = {{(EW - PW){1'b0}}, p2};
        aq_s  = {{(EW - 8){aq2[7]}}, aq2};
        e     = p_s - aq_s;
        lval  = {e, m2};
        l_ext = {{(PRW - LW){lval[LW-1]}}, lval};
        c_ext = {{(PRW - CF - 1){1'b0}}, (mode2 ? ONE_C : LN2_C)};
        prod  = l_ext * c_ext;
        rnd   = prod + HALF;
        r     = rnd >>> SH;
        z_nxt   = r[W-1:0];
        sat_nxt = 1'b0;
        if (zero2) begin
            z_nxt = {1'b1, {(W-1){1'b0}}};
        end else if (r > MAX_P) begin
            z_nxt   = MAX_P[W-1:0];
            sat_nxt = 1'b1;
        end else if (r < MIN_P) begin
            z_nxt   = MIN_P[W-1:0];
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0; z <= '0; out_tag <= '0;
            out_zero <= 1'b0; out_sat <= 1'b0;
        end else begin
            out_valid <= adv2 || (out_valid && !out_ready);
            if (adv2) begin
                z        <= z_nxt;
                out_tag  <= tag2;
                out_zero <= zero2;
                out_sat  <= sat_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_log_stream.sv
// Scoreboard bench for log_stream: expected results from a real-valued log model, checked by an output monitor.
module tb_log_stream;
    localparam int W = 16, LP = 10, OQ = 12, TW = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, mode = 1'b0, out_valid, out_ready;
    logic [W-1:0] a = '0, z;
    logic signed [7:0] a_quant = '0;
    logic [TW-1:0] in_tag = '0, out_tag;
    logic out_zero, out_sat, sat_clr = 1'b0;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    log_stream #(.W(W), .LOG_PREC(LP), .OUT_QUANT(OQ), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .a_quant(a_quant), .mode(mode), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .out_tag(out_tag), .out_zero(out_zero),
        .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    typedef struct { bit zero; real r; logic [TW-1:0] tag; } exp_t;
    exp_t q[$];
    int n_vec = 0, n_bad = 0;
    bit rnd_rdy = 1'b0, rdy_force = 1'b0;

    task automatic check(input bit ok, input string nm, input longint act, input longint req);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Exact log of the value defined by MSB position and truncated fraction, rounded half-up.
    function automatic exp_t model(input logic [W-1:0] av, input logic signed [7:0] aqv,
                                   input logic md, input logic [TW-1:0] tg);
        exp_t e;
        int p = 0;
        int fb;
        real lg;
        for (int i = 0; i < W; i++) if (av[i]) p = i;
        fb = ((int'(av) - (1 << p)) << LP) >> p;
        lg = real'(p - int'(aqv)) + $ln(1.0 + real'(fb) / real'(1 << LP)) / $ln(2.0);
        if (!md) lg = lg * $ln(2.0);
        e.zero = (av == '0);
        e.r    = $floor(lg * real'(1 << OQ) + 0.5);
        e.tag  = tg;
        return e;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Output monitor: pops the scoreboard on every output transfer, and checks hold stability.
    logic [W-1:0] h_z;
    logic [TW-1:0] h_tag;
    bit hold = 1'b0, h_zero, h_sat;
    always @(negedge clk) begin
        exp_t e;
        int c, d;
        bit ok;
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold)
                check(out_valid && z == h_z && out_tag == h_tag && out_zero == h_zero && out_sat == h_sat,
                      "hold_stable", longint'(z), longint'(h_z));
            hold = out_valid && !out_ready;
            h_z = z; h_tag = out_tag; h_zero = out_zero; h_sat = out_sat;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_output", longint'(z), -1);
                end else begin
                    e = q.pop_front();
                    if (e.zero) begin
                        ok = (z == 16'h8000) && out_zero && !out_sat && out_tag == e.tag;
                        check(ok, "zero_result", longint'(z), 32768);
                    end else begin
                        if (e.r > 32767.0) c = 32767;
                        else if (e.r < -32767.0) c = -32767;
                        else c = int'(e.r);
                        d = int'($signed(z)) - c;
                        ok = (d >= -2) && (d <= 2) && !out_zero && out_tag == e.tag;
                        if (e.r > 32769.0 || e.r < -32769.0) ok = ok && out_sat;
                        if (e.r < 32765.0 && e.r > -32765.0) ok = ok && !out_sat;
                        check(ok, "log_result", longint'($signed(z)), longint'(c));
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, a_quant, mode, in_tag));
        end
    end

    task automatic send(input logic [W-1:0] av, input logic signed [7:0] aqv,
                        input logic md, input logic [TW-1:0] tg);
        int t = 0;
        @(posedge clk); #1;
        a = av; a_quant = aqv; mode = md; in_tag = tg; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                check(1'b0, "accept_timeout", t, 200);
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [W-1:0] av;
        logic signed [7:0] aqv;
        av  = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom >> $urandom_range(0, 31));
        aqv = ($urandom_range(0, 9) < 7) ? 8'(int'($urandom_range(0, 48)) - 24) : 8'($urandom_range(0, 255));
        send(av, aqv, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(q.size() == 0, "drain", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, acc, seen;
        repeat (3) @(negedge clk);
        check(out_valid == 1'b0 && z == '0, "reset_out", longint'(z), 0);
        check(out_tag == '0 && !out_zero && !out_sat, "reset_flags", longint'(out_tag), 0);
        check(sat_count == 16'd0, "reset_sat_count", longint'(sat_count), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "ready_after_reset", longint'(in_ready), 1);
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);

        // single sample latency
        send(16'd1, 8'sd0, 1'b1, 4'd1);
        idle();
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        check(lat == 3, "latency", lat, 3);
        drain();

        send(16'd2, 8'sd0, 1'b1, 4'd3);
        send(16'd2, 8'sd0, 1'b0, 4'd5);
        send(16'd0, 8'sd0, 1'b1, 4'd7);
        idle();
        drain();
        check(sat_count == 16'd0, "sat_count_idle", longint'(sat_count), 0);

        send(16'hFFFF, -8'sd20, 1'b1, 4'd2);
        idle();
        drain();
        check(sat_count == 16'd1, "sat_count_inc", longint'(sat_count), 1);
        @(posedge clk); #1 sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        @(negedge clk);
        check(sat_count == 16'd0, "sat_count_clr", longint'(sat_count), 0);

        // capacity with downstream stalled
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            a = 16'($urandom); a_quant = 8'(int'($urandom_range(0, 16)) - 8);
            mode = 1'($urandom_range(0, 1)); in_tag = TW'(k + 8); in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
        end
        check(acc == 3, "capacity_accepted", acc, 3);
        check(in_ready == 1'b0, "capacity_full", longint'(in_ready), 0);
        idle();
        rdy_force = 1'b1;
        drain();
        for (int k = 0; k < 4; k++) send_rand();
        idle();
        drain();

        // randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) != 0) send_rand();
            else idle();
        end
        idle();
        rnd_rdy = 1'b0;
        drain();

        // reset with samples in flight
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        send_rand();
        send_rand();
        idle();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check(out_valid == 1'b0 && z == '0, "async_reset_out", longint'(out_valid), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        rdy_force = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "ready_after_rerun", longint'(in_ready), 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(seen == 0, "no_stale_output", seen, 0);
        check(q.size() == 0, "scoreboard_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
